// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one operation in flight.
module alu_share_arbiter #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned CTRL_W      = 5,
   parameter int unsigned ALU_LATENCY = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req0Valid,
   output logic              Req0Ready,
   input  logic [CTRL_W-1:0] Req0Op,
   input  logic [DATA_W-1:0] Req0A,
   input  logic [DATA_W-1:0] Req0B,
   output logic              Rsp0Valid,
   input  logic              Rsp0Ready,
   output logic [DATA_W-1:0] Rsp0Result,
   output logic              Rsp0Zero,
   input  logic              Req1Valid,
   output logic              Req1Ready,
   input  logic [CTRL_W-1:0] Req1Op,
   input  logic [DATA_W-1:0] Req1A,
   input  logic [DATA_W-1:0] Req1B,
   output logic              Rsp1Valid,
   input  logic              Rsp1Ready,
   output logic [DATA_W-1:0] Rsp1Result,
   output logic              Rsp1Zero,
   output logic [CTRL_W-1:0] AluControl,
   output logic [DATA_W-1:0] AluA,
   output logic [DATA_W-1:0] AluB,
   input  logic [DATA_W-1:0] AluResult,
   output logic              Busy
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              ptr;
   logic              owner;
   logic [CNT_W-1:0]  cnt;
   logic              grant_c;
   logic              accept_c;
   logic              done_c;
   logic              rsp_taken_c;

   // Grant selection: a lone requester wins, contention goes to the pointer.
   always_comb begin
      grant_c = 1'b0;
      if (Req0Valid && !Req1Valid) begin
         grant_c = 1'b0;
      end else if (!Req0Valid && Req1Valid) begin
         grant_c = 1'b1;
      end else if (Req0Valid && Req1Valid) begin
         grant_c = ptr;
      end
   end

   // Handshake and phase-complete qualifiers.
   always_comb begin
      Req0Ready   = (state == IDLE) && !grant_c && Req0Valid;
      Req1Ready   = (state == IDLE) &&  grant_c && Req1Valid;
      accept_c    = (state == IDLE) && (Req0Valid || Req1Valid);
      done_c      = (state == EXEC) && (cnt == CNT_W'(1));
      rsp_taken_c = (state == RESP) && (owner ? Rsp1Ready : Rsp0Ready);
      Busy        = (state != IDLE);
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_c)    state_nxt = EXEC;
         EXEC:    if (done_c)      state_nxt = RESP;
         RESP:    if (rsp_taken_c) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Arbitration pointer, owner and latency counter.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ptr   <= 1'b0;
         owner <= 1'b0;
         cnt   <= '0;
      end else if (accept_c) begin
         ptr   <= ~grant_c;
         owner <= grant_c;
         cnt   <= CNT_W'(ALU_LATENCY);
      end else if (state == EXEC) begin
         cnt   <= cnt - CNT_W'(1);
      end
   end

   // ALU input registers: loaded on accept, otherwise hold their last values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         AluControl <= '0;
         AluA       <= '0;
         AluB       <= '0;
      end else if (accept_c) begin
         AluControl <= grant_c ? Req1Op : Req0Op;
         AluA       <= grant_c ? Req1A  : Req0A;
         AluB       <= grant_c ? Req1B  : Req0B;
      end
   end

   // Response slot 0: capture on completion for owner 0, clear valid on consume.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Rsp0Valid  <= 1'b0;
         Rsp0Result <= '0;
         Rsp0Zero   <= 1'b0;
      end else if (done_c && !owner) begin
         Rsp0Valid  <= 1'b1;
         Rsp0Result <= AluResult;
         Rsp0Zero   <= (AluResult == '0);
      end else if (rsp_taken_c && !owner) begin
         Rsp0Valid  <= 1'b0;
      end
   end

   // Response slot 1: capture on completion for owner 1, clear valid on consume.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Rsp1Valid  <= 1'b0;
         Rsp1Result <= '0;
         Rsp1Zero   <= 1'b0;
      end else if (done_c && owner) begin
         Rsp1Valid  <= 1'b1;
         Rsp1Result <= AluResult;
         Rsp1Zero   <= (AluResult == '0);
      end else if (rsp_taken_c && owner) begin
         Rsp1Valid  <= 1'b0;
      end
   end

endmodule
